alu_shift_sched: RTL and testbench
==================================

ALU_SHIFT_SCHED -- requirements
Module: alu_shift_sched

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  block accepts requester N's operation this cycle.
REQ-006 reqN_op  input  4  4'b0000 shl, 4'b0001 shr, 4'b0010 sar, 4'b0011 sal; other codes are illegal.
REQ-007 reqN_a  input  32  value to shift.
REQ-008 reqN_b  input  32  shift amount, unsigned.
REQ-009 rsp_valid  output  1  result held on rsp_* is valid.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_out  output  32  shifted result.
REQ-013 rsp_flags  output  5  {err, neg, zero, ovf, carry}.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE.
REQ-016 Accept rule: in IDLE only, ready=1 for the granted requester and 0 for the other; a transfer occurs when valid&&ready.
REQ-017 Arbitration: round-robin. A sole requester wins. When both are valid, the requester not granted last wins. The last-grant pointer resets to 1, so req0 wins the first tie.
REQ-018 On accept: latch op, a and id; set cnt = min(b, 32), capped; clear the carry and ovf accumulators.
REQ-019 Illegal op on accept: go directly to DONE with out=0 and flags=5'b10000; no shift cycles are spent.
REQ-020 Legal op with cnt=0: go directly to DONE with out=a, carry=0, ovf=0.
REQ-021 SHIFT: each cycle shift the working register by 1 bit and decrement cnt; leave SHIFT for DONE in the cycle cnt reaches 0.
REQ-022 shl/sal shift in 0 at the LSB; shr shifts in 0 at the MSB; sar replicates bit 31.
REQ-023 carry = last bit shifted out: a[32-n] for left shifts, a[n-1] for right shifts (n=cnt, 1..32).
REQ-024 ovf = 1 for sal only, when bit 31 of the working register changes on any step; ovf = 0 for the other ops.
REQ-025 zero = (out==0); neg = out[31]; both are computed on the final value.
REQ-026 Latency: with n = capped shift count, rsp_valid rises n+1 cycles after the accept edge for n>0, and 1 cycle after for n=0 or an illegal op.
REQ-027 DONE: hold all rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_valid&&rsp_ready, go to IDLE with no new accept in the same cycle.
REQ-028 rsp_valid = 1 only in DONE; rsp_* outputs come from registers.
REQ-029 Inputs presented while busy are ignored; no operation is lost because ready stays 0.

Reset
REQ-030 rst_n=0 at a clock edge forces IDLE, rsp_valid=0, rsp_out=0, rsp_flags=0, rsp_id=0, cnt=0, and last-grant=1, from any state.
REQ-031 Reset during SHIFT or DONE discards the in-flight operation; no rsp handshake completes for it.
REQ-032 While rst_n=0, reqN_ready=0 and busy=0.

Structure
REQ-033 Shared package alu_pkg: op-code constants (OP_SHL, OP_SHR, OP_SAR, OP_SAL), flag bit indices, and the FSM state enum.
REQ-034 Sub-module alu_shift_step: combinational one-bit shift of 32 bits by op, giving the next value and the bit shifted out; the FSM instantiates it once.

Verification
REQ-035 req0 shl a=32'h8000_0001, b=1, rsp_ready=1 -> after 2 cycles: out=32'h0000_0002, carry=1, zero=0, neg=0, id=0.
REQ-036 req1 sar a=32'h8000_0000, b=40 (capped to 32) -> after 33 cycles: out=32'hFFFF_FFFF, carry=1, neg=1.
REQ-037 sal a=32'h4000_0000, b=1 -> out=32'h8000_0000, ovf=1. shr a=32'h0000_0001, b=1 -> out=0, zero=1, carry=1.
REQ-038 Both requesters valid continuously -> grants alternate 0,1,0,1; op 4'b0111 -> after 1 cycle flags=5'b10000, out=0.
REQ-039 rsp_ready held 0 for 5 cycles in DONE -> rsp_* remain stable and both reqN_ready stay 0; rst_n=0 mid-SHIFT -> IDLE next cycle, rsp_valid never asserted.

Source files
------------

// File: rtl/alu_shift_sched_pkg.sv
// Shared constants, flag positions and FSM state type for the shift scheduler.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_SHL = 4'b0000;
  localparam logic [3:0] OP_SHR = 4'b0001;
  localparam logic [3:0] OP_SAR = 4'b0010;
  localparam logic [3:0] OP_SAL = 4'b0011;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ERR   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/alu_shift_sched_if.sv
// Request/response bundle between two requesters, the shift scheduler and its consumer.
interface alu_shift_sched_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_out;
  logic [4:0]        rsp_flags;
  logic              busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_flags, busy
  );

endinterface

// File: rtl/alu_shift_sched_step.sv
// One-bit shift of the working register, returning the new value and the bit that fell out.
module alu_shift_step
  import alu_pkg::*;
(
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_value,
  output logic [DATA_W-1:0] o_next,
  output logic              o_shift_out
);

  always_comb begin
    o_next      = i_value;
    o_shift_out = 1'b0;
    case (i_op)
      OP_SHL, OP_SAL: begin
        o_next      = {i_value[DATA_W-2:0], 1'b0};
        o_shift_out = i_value[DATA_W-1];
      end
      OP_SHR: begin
        o_next      = {1'b0, i_value[DATA_W-1:1]};
        o_shift_out = i_value[0];
      end
      OP_SAR: begin
        o_next      = {i_value[DATA_W-1], i_value[DATA_W-1:1]};
        o_shift_out = i_value[0];
      end
      default: begin
        o_next      = i_value;
        o_shift_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_sched.sv
// Round-robin two-requester shift unit: accepts one operation at a time, shifts
// it one bit per cycle and holds the result until the consumer takes it.
module alu_shift_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic              clk,
  input logic              rst_n,
  alu_shift_sched_if.slave bus
);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_last;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_work;
  logic [5:0]         r_cnt;
  logic               r_ovf;
  logic               r_id;
  logic [WIDTH-1:0]   r_out;
  logic [4:0]         r_flags;

  logic               w_idle;
  logic               w_any;
  logic               w_gnt_id;
  logic               w_accept;
  logic [3:0]         w_sel_op;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [5:0]         w_cap_cnt;
  logic               w_legal;
  logic [WIDTH-1:0]   w_step_next;
  logic               w_step_out;
  logic               w_step_ovf;
  logic               w_last_step;
  logic [4:0]         w_zero_flags;
  logic [4:0]         w_fin_flags;

  // On a tie the requester that did not win last time is served.
  assign w_idle   = rst_n && (r_state == ST_IDLE);
  assign w_any    = bus.req0_valid || bus.req1_valid;
  assign w_gnt_id = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
  assign w_accept = w_idle && w_any;

  assign bus.req0_ready = w_accept && !w_gnt_id;
  assign bus.req1_ready = w_accept && w_gnt_id;

  assign w_sel_op  = w_gnt_id ? bus.req1_op : bus.req0_op;
  assign w_sel_a   = w_gnt_id ? bus.req1_a  : bus.req0_a;
  assign w_sel_b   = w_gnt_id ? bus.req1_b  : bus.req0_b;
  assign w_cap_cnt = (|w_sel_b[WIDTH-1:5]) ? 6'd32 : {1'b0, w_sel_b[4:0]};
  assign w_legal   = is_legal_op(w_sel_op);

  alu_shift_step u_step (
    .i_op        (r_op),
    .i_value     (r_work),
    .o_next      (w_step_next),
    .o_shift_out (w_step_out)
  );

  assign w_step_ovf  = (r_op == OP_SAL) && (w_step_next[WIDTH-1] != r_work[WIDTH-1]);
  assign w_last_step = (r_cnt == 6'd1);

  always_comb begin
    w_zero_flags                = '0;
    w_zero_flags[FLAG_NEG]      = w_sel_a[WIDTH-1];
    w_zero_flags[FLAG_ZERO]     = (w_sel_a == '0);

    w_fin_flags                 = '0;
    w_fin_flags[FLAG_NEG]       = w_step_next[WIDTH-1];
    w_fin_flags[FLAG_ZERO]      = (w_step_next == '0);
    w_fin_flags[FLAG_OVF]       = r_ovf || w_step_ovf;
    w_fin_flags[FLAG_CARRY]     = w_step_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Illegal ops and zero-length shifts skip SHIFT and complete in one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_legal || (w_cap_cnt == 6'd0)) w_next_state = ST_DONE;
          else                                 w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_step) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_op    <= OP_SHL;
      r_work  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_id    <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= w_sel_op;
            r_id   <= w_gnt_id;
            r_last <= w_gnt_id;
            r_work <= w_sel_a;
            r_cnt  <= w_cap_cnt;
            r_ovf  <= 1'b0;
            if (!w_legal) begin
              r_out              <= '0;
              r_flags            <= '0;
              r_flags[FLAG_ERR]  <= 1'b1;
            end else if (w_cap_cnt == 6'd0) begin
              r_out   <= w_sel_a;
              r_flags <= w_zero_flags;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_step_next;
          r_cnt  <= r_cnt - 6'd1;
          r_ovf  <= r_ovf || w_step_ovf;
          if (w_last_step) begin
            r_out   <= w_step_next;
            r_flags <= w_fin_flags;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_out   = r_out;
  assign bus.rsp_flags = r_flags;
  assign bus.busy      = rst_n && (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_shift_sched.sv
// Randomized and directed checks of alu_shift_sched against a plain-arithmetic shift model.
module tb_alu_shift_sched;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_shift_sched_if bus_if ();

  alu_shift_sched #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired, simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Expected result from the arithmetic meaning of each op; lat counts the accept edge as 1.
  function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] out, output logic [4:0] flags, output int lat);
    int          n;
    logic [63:0] w;
    logic [63:0] seg;
    logic        carry;
    logic        ovf;
    n     = (b > 32) ? 32 : int'(b);
    carry = 1'b0;
    ovf   = 1'b0;
    if (op > 4'd3) begin
      out   = 32'h0;
      flags = 5'b10000;
      lat   = 1;
      return;
    end
    if (op == 4'd0 || op == 4'd3) begin
      w = {32'h0, a} << n;
      if (n > 0) carry = a[32-n];
    end else if (op == 4'd1) begin
      w = {32'h0, a} >> n;
      if (n > 0) carry = a[n-1];
    end else begin
      w = {{32{a[31]}}, a} >> n;
      if (n > 0) carry = a[n-1];
    end
    out = w[31:0];
    if (op == 4'd3 && n > 0) begin
      seg = {a, 32'h0} >> (63 - n);
      ovf = !((seg == 64'h0) || (seg == ((64'd1 << (n + 1)) - 64'd1)));
    end
    flags = {1'b0, out[31], (out == 32'h0), ovf, carry};
    lat   = (n == 0) ? 1 : n + 1;
  endfunction

  task automatic clearInputs();
    bus_if.req0_valid = 1'b0;
    bus_if.req0_op    = 4'h0;
    bus_if.req0_a     = 32'h0;
    bus_if.req0_b     = 32'h0;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_op    = 4'h0;
    bus_if.req1_a     = 32'h0;
    bus_if.req1_b     = 32'h0;
    bus_if.rsp_ready  = 1'b1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    clearInputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one op from one requester, waits for the result and completes the handshake.
  task automatic applyStimulus(input int req, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] out, output logic [4:0] flags,
                               output logic id, output bit to);
    int guard;
    to  = 1'b0;
    lat = 0;
    out = 32'h0; flags = 5'h0; id = 1'b0;
    @(negedge clk);
    bus_if.rsp_ready = 1'b1;
    if (req == 0) begin
      bus_if.req0_valid = 1'b1; bus_if.req0_op = op; bus_if.req0_a = a; bus_if.req0_b = b;
    end else begin
      bus_if.req1_valid = 1'b1; bus_if.req1_op = op; bus_if.req1_a = a; bus_if.req1_b = b;
    end
    #1;
    guard = 0;
    while (!((req == 0) ? bus_if.req0_ready : bus_if.req1_ready) && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      to = 1'b1;
      bus_if.req0_valid = 1'b0;
      bus_if.req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus_if.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus_if.rsp_valid) to = 1'b1;
    out   = bus_if.rsp_out;
    flags = bus_if.rsp_flags;
    id    = bus_if.rsp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clearInputs();
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus_if.req0_ready, bus_if.req1_ready, bus_if.busy} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_ready_busy got=%b want=000", {bus_if.req0_ready, bus_if.req1_ready, bus_if.busy});
    end
    vectors++;
    if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_flags, bus_if.rsp_out} !== 39'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp got valid=%b id=%b flags=%b out=%h want all zero",
               bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_flags, bus_if.rsp_out);
    end
    clearInputs();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus_if.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_busy got=%b want=0", bus_if.busy);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  ops  [5] = '{4'h0, 4'h2, 4'h3, 4'h1, 4'h7};
    logic [31:0] as   [5] = '{32'h8000_0001, 32'h8000_0000, 32'h4000_0000, 32'h0000_0001, 32'h1234_5678};
    logic [31:0] bs   [5] = '{32'd1, 32'd40, 32'd1, 32'd1, 32'd3};
    int          reqs [5] = '{0, 1, 0, 1, 0};
    logic [31:0] want_out [5] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h0};
    logic [4:0]  want_flg [5] = '{5'b00001, 5'b01001, 5'b01010, 5'b00101, 5'b10000};
    int          want_lat [5] = '{2, 33, 2, 2, 1};
    int lat; logic [31:0] out; logic [4:0] flags; logic id; bit to;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(reqs[i], ops[i], as[i], bs[i], lat, out, flags, id, to);
      vectors++;
      if (to || out !== want_out[i] || flags !== want_flg[i] || lat != want_lat[i] || id !== 1'(reqs[i])) begin
        miscompares++;
        $display("[TB] FAIL directed_%0d got out=%h flags=%b lat=%0d id=%b to=%0d want out=%h flags=%b lat=%0d id=%0d",
                 i, out, flags, lat, id, to, want_out[i], want_flg[i], want_lat[i], reqs[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] out; logic [4:0] flags; logic id; bit to;
    int e_lat; logic [31:0] e_out; logic [4:0] e_flags;
    int req; logic [3:0] op; logic [31:0] a; logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      req = int'($urandom_range(0, 1));
      op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 32));
        1:       b = $urandom;
        2:       b = 32'($urandom_range(31, 33));
        default: b = 32'($urandom_range(1, 8));
      endcase
      refModel(op, a, b, e_out, e_flags, e_lat);
      applyStimulus(req, op, a, b, lat, out, flags, id, to);
      vectors++;
      if (to || out !== e_out || flags !== e_flags) begin
        miscompares++;
        $display("[TB] FAIL random_%0d_result op=%h a=%h b=%0d got out=%h flags=%b to=%0d want out=%h flags=%b",
                 i, op, a, b, out, flags, to, e_out, e_flags);
      end
      vectors++;
      if (lat != e_lat || id !== 1'(req)) begin
        miscompares++;
        $display("[TB] FAIL random_%0d_timing got lat=%0d id=%b want lat=%0d id=%0d", i, lat, id, e_lat, req);
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    applyReset();
    @(negedge clk);
    bus_if.rsp_ready  = 1'b1;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'h0; bus_if.req0_a = 32'hAAAA_0000; bus_if.req0_b = 32'd0;
    bus_if.req1_valid = 1'b1; bus_if.req1_op = 4'h0; bus_if.req1_a = 32'h0000_BBBB; bus_if.req1_b = 32'd0;
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!bus_if.rsp_valid && guard < 20);
      vectors++;
      if (!bus_if.rsp_valid || bus_if.rsp_id !== 1'(k % 2) ||
          bus_if.rsp_out !== ((k % 2 == 0) ? 32'hAAAA_0000 : 32'h0000_BBBB)) begin
        miscompares++;
        $display("[TB] FAIL grant_%0d got valid=%b id=%b out=%h want id=%0d", k, bus_if.rsp_valid,
                 bus_if.rsp_id, bus_if.rsp_out, k % 2);
      end
      vectors++;
      if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL grant_%0d_ready_in_done got=%b want=00", k, {bus_if.req0_ready, bus_if.req1_ready});
      end
    end
    clearInputs();
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int guard; int e_lat; logic [31:0] e_out; logic [4:0] e_flags; logic [31:0] a;
    a = $urandom;
    refModel(4'h0, a, 32'd3, e_out, e_flags, e_lat);
    @(negedge clk);
    bus_if.rsp_ready  = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'h0; bus_if.req0_a = a; bus_if.req0_b = 32'd3;
    @(posedge clk); #1;
    bus_if.req0_valid = 1'b0;
    bus_if.req1_valid = 1'b1; bus_if.req1_op = 4'h1; bus_if.req1_a = 32'hFFFF_FFFF; bus_if.req1_b = 32'd2;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus_if.rsp_valid && guard < 20);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (!bus_if.rsp_valid || bus_if.rsp_out !== e_out || bus_if.rsp_flags !== e_flags || bus_if.rsp_id !== 1'b0 ||
          {bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle_%0d got valid=%b out=%h flags=%b id=%b rdy=%b want valid=1 out=%h flags=%b id=0 rdy=00",
                 c, bus_if.rsp_valid, bus_if.rsp_out, bus_if.rsp_flags, bus_if.rsp_id,
                 {bus_if.req0_ready, bus_if.req1_ready}, e_out, e_flags);
      end
      @(negedge clk);
    end
    bus_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus_if.rsp_valid, bus_if.busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL hold_release got valid,busy=%b want=00", {bus_if.rsp_valid, bus_if.busy});
    end
    bus_if.req1_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus_if.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_no_accept_after_release got busy=%b want=0", bus_if.busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    @(negedge clk);
    bus_if.rsp_ready  = 1'b1;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 4'h1; bus_if.req0_a = 32'hDEAD_BEEF; bus_if.req0_b = 32'd20;
    @(posedge clk); #1;
    bus_if.req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus_if.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midshift_busy got=%b want=1", bus_if.busy);
    end
    rst_n = 1'b0;
    bus_if.req1_valid = 1'b1;
    #1;
    vectors++;
    if ({bus_if.busy, bus_if.req0_ready, bus_if.req1_ready} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL midshift_in_reset got=%b want=000", {bus_if.busy, bus_if.req0_ready, bus_if.req1_ready});
    end
    @(posedge clk); #1;
    bus_if.req1_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({bus_if.busy, bus_if.rsp_valid, bus_if.rsp_out} !== 34'h0) begin
      miscompares++;
      $display("[TB] FAIL midshift_after_reset got busy=%b valid=%b out=%h want 0/0/0",
               bus_if.busy, bus_if.rsp_valid, bus_if.rsp_out);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.rsp_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("[TB] FAIL midshift_ghost_response got=%0d cycles want=0", seen);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clearInputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_hold();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
